// File: rtl/unit_pkt_pkg.sv
// unit_pkt_pkg: shared encodings for the packet receive unit.
// Build option: UNIT_PKT_RX_CHECK_EN enables protocol checking and the ERR state.
package unit_pkt_pkg;

`ifdef UNIT_PKT_RX_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BODY = 3'd1,
    ST_KEY  = 3'd2,
    ST_FULL = 3'd3,
    ST_ERR  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BODY = 3'd1,
    ST_KEY  = 3'd2,
    ST_FULL = 3'd3
  } state_e;
`endif

  // Word offsets inside unit memory.
  localparam int OFF_CNT      = 0;
  localparam int OFF_SALT_LEN = 1;
  localparam int OFF_SALT     = 2;
  localparam int OFF_IDS      = 6;
  localparam int OFF_KEYLEN   = 8;
  localparam int OFF_KEY      = 10;

  // Header codes carried on ctrl=1 bytes while idle.
  localparam logic [7:0] HDR_DATA      = 8'h00;
  localparam logic [2:0] HDR_INIT      = 3'b001;
  // Bit 1 of an init byte is a don't-care; senders use it (e.g. 0x2B).
  localparam logic [2:0] HDR_INIT_MASK = 3'b101;

  function automatic logic is_init_hdr(input logic [7:0] b);
    return (b[2:0] & HDR_INIT_MASK) == HDR_INIT;
  endfunction

  // Key bytes on the wire: key_len rounded up to a whole word.
  function automatic logic [8:0] key_bytes_padded(input logic [7:0] key_len);
    return ({1'b0, key_len} + 9'd3) & ~9'd3;
  endfunction

endpackage

// File: rtl/unit_pkt_fifo.sv
// unit_pkt_fifo: 9-bit synchronous FIFO ({ctrl, byte}) with free-entry count.
// A push while full is dropped; push and pop in one cycle keep occupancy.
module unit_pkt_fifo #(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [8:0]    push_data,
  input  logic          pop,
  output logic [8:0]    pop_data,
  output logic          empty,
  output logic [CW-1:0] free_cnt
);

  logic [8:0]    mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] used;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Occupancy, flags and pointer advance.
  always_comb begin
    used     = wr_ptr_q - rd_ptr_q;
    empty    = (used == '0);
    full     = (used == CW'(DEPTH));
    free_cnt = CW'(DEPTH) - used;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + CW'(1) : rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[PW-1:0]];
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/unit_pkt_rx.sv
// unit_pkt_rx: buffers broadcast bytes, parses init/data packets and writes
// data packets word by word into unit memory.
// Build option: UNIT_PKT_RX_CHECK_EN enables protocol checks, sticky err and ERR.
// Handshake: a byte is taken on every cycle wr_en=1 (no back-pressure other
// than afull, which the sender honours two cycles late); pkt_valid holds until
// pkt_consumed is seen in FULL.
module unit_pkt_rx
  import unit_pkt_pkg::*;
#(
  parameter  int WORD_MAX_LEN = 64,
  parameter  int FIFO_DEPTH   = 16,
  parameter  int AFULL_MARGIN = 4,
  localparam int AW           = $clog2(10 + WORD_MAX_LEN / 4),
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    in,
  input  logic          in_ctrl,
  input  logic          wr_en,
  output logic          afull,
  output logic          ready,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_dout,
  output logic          pkt_valid,
  input  logic          pkt_consumed,
  output logic          init_valid,
  output logic [4:0]    init_data,
  output logic          err,
  output state_e        dbg_state
);

  logic [8:0]    fifo_rd;
  logic          fifo_empty;
  logic [CW-1:0] fifo_free;
  logic          fifo_pop;

  state_e        state_q, state_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   buf_q, buf_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_dout_q, mem_dout_d;
  logic          init_valid_q, init_valid_d;
  logic [4:0]    init_data_q, init_data_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [7:0]    pop_byte;
  logic          pop_ctrl;
  logic [31:0]   asm_word;
  logic          take_byte;
  logic          close_pkt;

`ifdef UNIT_PKT_RX_CHECK_EN
  logic [7:0]    key_len_q, key_len_d;
  logic [8:0]    key_cnt_q, key_cnt_d, key_cnt_n;
  logic          overflow;
`endif

  unit_pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (wr_en),
    .push_data ({in_ctrl, in}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty),
    .free_cnt  (fifo_free)
  );

  // Parser FSM: next state, word assembly and registered output values.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    mem_wr_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    init_valid_d = 1'b0;
    init_data_d  = init_data_q;
    err_d        = err_q;
    fifo_pop     = 1'b0;
    take_byte    = 1'b0;
    close_pkt    = 1'b0;
    pop_ctrl     = fifo_rd[8];
    pop_byte     = fifo_rd[7:0];
    // Bytes above the current position are zero so a short final word is clean.
    asm_word     = (byte_idx_q == 2'd0) ? 32'h0 : {8'h00, buf_q};
    asm_word[{byte_idx_q, 3'b000} +: 8] = pop_byte;
`ifdef UNIT_PKT_RX_CHECK_EN
    key_len_d    = key_len_q;
    key_cnt_d    = key_cnt_q;
    key_cnt_n    = key_cnt_q + 9'd1;
    overflow     = wr_en && (fifo_free == '0);
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (pop_ctrl && pop_byte == HDR_DATA) begin
            state_d    = ST_BODY;
            word_idx_d = '0;
            byte_idx_d = 2'd0;
`ifdef UNIT_PKT_RX_CHECK_EN
            key_cnt_d  = '0;
`endif
          end else if (pop_ctrl && is_init_hdr(pop_byte)) begin
            init_valid_d = 1'b1;
            init_data_d  = pop_byte[7:3];
          end else begin
`ifdef UNIT_PKT_RX_CHECK_EN
            err_d = 1'b1;
`endif
          end
        end
      end

      ST_BODY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (pop_ctrl) begin
`ifdef UNIT_PKT_RX_CHECK_EN
            err_d = 1'b1;
`else
            take_byte = 1'b1;
            close_pkt = 1'b1;
            state_d   = ST_FULL;
`endif
          end else begin
            take_byte = 1'b1;
`ifdef UNIT_PKT_RX_CHECK_EN
            if (word_idx_q == AW'(OFF_KEYLEN) && byte_idx_q == 2'd0) begin
              key_len_d = pop_byte;
              if (pop_byte == 8'd0 || {24'h0, pop_byte} > 32'(WORD_MAX_LEN)) err_d = 1'b1;
            end
`endif
            if (byte_idx_q == 2'd3 && word_idx_q == AW'(OFF_KEY - 1)) state_d = ST_KEY;
          end
        end
      end

      ST_KEY: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef UNIT_PKT_RX_CHECK_EN
          key_cnt_d = key_cnt_n;
          // ctrl must land exactly on the last padded key byte: earlier is a
          // short packet, a plain byte there means the count would be exceeded.
          if (pop_ctrl != (key_cnt_n == key_bytes_padded(key_len_q))) begin
            err_d = 1'b1;
          end else begin
            take_byte = 1'b1;
            if (pop_ctrl) begin
              close_pkt = 1'b1;
              state_d   = ST_FULL;
            end
          end
`else
          take_byte = 1'b1;
          if (pop_ctrl) begin
            close_pkt = 1'b1;
            state_d   = ST_FULL;
          end
`endif
        end
      end

      ST_FULL: begin
        if (pkt_consumed) state_d = ST_IDLE;
      end

`ifdef UNIT_PKT_RX_CHECK_EN
      ST_ERR: begin
        fifo_pop = !fifo_empty;
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (take_byte) begin
      byte_idx_d = byte_idx_q + 2'd1;
      buf_d      = asm_word[23:0];
      if (byte_idx_q == 2'd3 || close_pkt) begin
        mem_wr_en_d = 1'b1;
        mem_addr_d  = word_idx_q;
        mem_dout_d  = asm_word;
        word_idx_d  = word_idx_q + AW'(1);
      end
    end

`ifdef UNIT_PKT_RX_CHECK_EN
    if (overflow) err_d = 1'b1;
    if (err_d) state_d = ST_ERR;
`endif

    ready_d = (state_q == ST_IDLE) && fifo_empty;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      buf_q        <= '0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      init_valid_q <= 1'b0;
      init_data_q  <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef UNIT_PKT_RX_CHECK_EN
      key_len_q    <= '0;
      key_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      init_valid_q <= init_valid_d;
      init_data_q  <= init_data_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
`ifdef UNIT_PKT_RX_CHECK_EN
      key_len_q    <= key_len_d;
      key_cnt_q    <= key_cnt_d;
`endif
    end
  end

  assign afull      = fifo_free <= CW'(AFULL_MARGIN);
  assign ready      = ready_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_dout   = mem_dout_q;
  assign pkt_valid  = (state_q == ST_FULL);
  assign init_valid = init_valid_q;
  assign init_data  = init_data_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_unit_pkt_rx.sv
// tb_unit_pkt_rx: scenario bench for unit_pkt_rx with a memory-write scoreboard.
module tb_unit_pkt_rx;
  import unit_pkt_pkg::*;

  localparam int AW = $clog2(10 + 64 / 4);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [7:0]    in_byte = '0;
  logic          in_ctrl = 1'b0;
  logic          wr_en = 1'b0;
  logic          afull, ready, mem_wr_en, pkt_valid, init_valid, err;
  logic          pkt_consumed = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_dout;
  logic [4:0]    init_data;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int init_pulses = 0;
  bit afull_seen = 1'b0;

  logic [AW+31:0] exp_q[$];
  logic [4:0]     init_exp_q[$];
  logic [8:0]     tx_q[$];
  logic [31:0]    mem_seen [2**AW];

  unit_pkt_rx dut (
    .CLK(CLK), .RST_N(RST_N), .in(in_byte), .in_ctrl(in_ctrl), .wr_en(wr_en),
    .afull(afull), .ready(ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .pkt_valid(pkt_valid), .pkt_consumed(pkt_consumed),
    .init_valid(init_valid), .init_data(init_data), .err(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Scoreboard: memory writes and init pulses checked against expected queues.
  always @(negedge CLK) begin
    logic [AW+31:0] exp_w;
    logic [4:0]     exp_i;
    if (RST_N && afull) afull_seen = 1'b1;
    if (RST_N && mem_wr_en) begin
      wr_count++;
      mem_seen[mem_addr] = mem_dout;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write_unexpected: got addr=%0d data=%h, no write expected", mem_addr, mem_dout);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_dout} !== exp_w) begin
          errors++;
          $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_dout, exp_w[AW+31:32], exp_w[31:0]);
        end
      end
    end
    if (RST_N && init_valid) begin
      init_pulses++;
      checks++;
      if (init_exp_q.size() == 0) begin
        errors++;
        $display("FAIL init_unexpected: got init_data=%0d, no pulse expected", init_data);
      end else begin
        exp_i = init_exp_q.pop_front();
        if (init_data !== exp_i) begin
          errors++;
          $display("FAIL init_data: got %0d, expected %0d", init_data, exp_i);
        end
      end
    end
  end

  // Driver: sends tx_q, stopping two cycles after afull is seen.
  task automatic drive_bytes(input int max_cycles);
    logic [1:0] af_hist;
    int cyc;
    af_hist = 2'b00;
    cyc = 0;
    while (tx_q.size() > 0 && cyc < max_cycles) begin
      @(negedge CLK);
      af_hist = {af_hist[0], afull};
      if (!af_hist[1]) begin
        {in_ctrl, in_byte} = tx_q.pop_front();
        wr_en = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      cyc++;
    end
    @(negedge CLK);
    wr_en = 1'b0;
    in_ctrl = 1'b0;
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL drive_timeout: %0d bytes left, expected 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  // Builds a data packet into tx_q and its expected memory words into exp_q.
  // ctrl_at > 0 cuts the packet with ctrl=1 on that (1-based) key byte.
  task automatic build_pkt(input int key_len, input bit abc_key, input int ctrl_at);
    logic [7:0]  b[$];
    logic [31:0] w;
    int nkey, nbytes, nwords;
    nkey = ((key_len + 3) / 4) * 4;
    for (int i = 0; i < 40; i++) b.push_back(8'($urandom_range(0, 255)));
    b[32] = 8'(key_len);
    b[33] = 8'h00;
    b[34] = 8'h00;
    b[35] = 8'h00;
    for (int i = 0; i < nkey; i++)
      b.push_back((i < key_len) ? (abc_key ? 8'(8'h61 + i) : 8'($urandom_range(0, 255))) : 8'h00);
    nbytes = (ctrl_at > 0) ? 40 + ctrl_at : 40 + nkey;
    tx_q.push_back({1'b1, 8'h00});
    for (int i = 0; i < nbytes; i++) tx_q.push_back({(i == nbytes - 1), b[i]});
`ifdef UNIT_PKT_RX_CHECK_EN
    nwords = (ctrl_at > 0) ? (nbytes - 1) / 4 : nbytes / 4;
`else
    nwords = (nbytes + 3) / 4;
`endif
    for (int k = 0; k < nwords; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (4 * k + j < nbytes) w[8*j +: 8] = b[4*k + j];
      exp_q.push_back({AW'(k), w});
    end
  endtask

  task automatic wait_pkt_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (pkt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge CLK);
  endtask

  task automatic pulse_consume();
    @(negedge CLK);
    pkt_consumed = 1'b1;
    @(negedge CLK);
    pkt_consumed = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({afull, ready, mem_wr_en, pkt_valid, init_valid, init_data, err, mem_addr, mem_dout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got afull=%b ready=%b wr=%b pv=%b iv=%b id=%0d err=%b addr=%0d dout=%h, expected all 0",
               afull, ready, mem_wr_en, pkt_valid, init_valid, init_data, err, mem_addr, mem_dout);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_idle_ready: got ready=%b state=%0d, expected ready=1 state=0", ready, dbg_state);
    end
  endtask

  task automatic test_init();
    init_pulses = 0;
    init_exp_q.push_back(5'd5);
    init_exp_q.push_back(5'd5);
    tx_q.push_back({1'b1, 8'h2B});
    tx_q.push_back({1'b1, 8'h2B});
    drive_bytes(20);
    repeat (4) @(negedge CLK);
    checks++;
    if (init_pulses !== 2 || init_exp_q.size() != 0) begin
      errors++;
      $display("FAIL init_pulses: got %0d pulses, expected 2", init_pulses);
    end
    checks++;
    if (init_data !== 5'd5) begin
      errors++;
      $display("FAIL init_latched: got %0d, expected 5", init_data);
    end
    checks++;
    if (ready !== 1'b1 || err !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL init_idle: got ready=%b err=%b state=%0d, expected ready=1 err=0 state=0", ready, err, dbg_state);
    end
  endtask

  task automatic test_data_pkt();
    int w0;
    bit ok;
    w0 = wr_count;
    build_pkt(5, 1'b1, 0);
    drive_bytes(200);
    wait_pkt_valid(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL data_pkt_valid: got pkt_valid=0 after budget, expected 1");
    end
    checks++;
    if (wr_count - w0 !== 12 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL data_write_count: got %0d writes (%0d pending), expected 12", wr_count - w0, exp_q.size());
    end
    checks++;
    if (mem_seen[8] !== 32'h0000_0005) begin
      errors++;
      $display("FAIL data_word8: got %h, expected 00000005", mem_seen[8]);
    end
    checks++;
    if (mem_seen[11][7:0] !== 8'h65) begin
      errors++;
      $display("FAIL data_word11: got byte0=%h, expected 65", mem_seen[11][7:0]);
    end
    checks++;
    if (pkt_valid !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL data_full_hold: got pkt_valid=%b ready=%b, expected 1 0", pkt_valid, ready);
    end
  endtask

  task automatic test_consume();
    bit ok;
    @(negedge CLK);
    pkt_consumed = 1'b1;
    @(negedge CLK);
    pkt_consumed = 1'b0;
    checks++;
    if (pkt_valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL consume_next: got pkt_valid=%b ready=%b, expected 0 0", pkt_valid, ready);
    end
    @(negedge CLK);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL consume_ready: got ready=%b, expected 1", ready);
    end
    // A consume pulse while idle must be ignored.
    pulse_consume();
    checks++;
    if (dbg_state !== ST_IDLE || ready !== 1'b1) begin
      errors++;
      $display("FAIL consume_idle_ignored: got state=%0d ready=%b, expected 0 1", dbg_state, ready);
    end
    build_pkt(12, 1'b0, 0);
    drive_bytes(200);
    wait_pkt_valid(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL second_pkt: got valid=%b pending=%0d, expected valid=1 pending=0", ok, exp_q.size());
    end
    pulse_consume();
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_afull();
    bit ok;
    build_pkt(7, 1'b0, 0);
    drive_bytes(200);
    wait_pkt_valid(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL afull_first_pkt: got pkt_valid=0, expected 1");
    end
    afull_seen = 1'b0;
    build_pkt(4, 1'b0, 0);
    fork
      drive_bytes(500);
      begin
        repeat (40) @(negedge CLK);
        pkt_consumed = 1'b1;
        @(negedge CLK);
        pkt_consumed = 1'b0;
      end
    join
    wait_pkt_valid(100, ok);
    checks++;
    if (afull_seen !== 1'b1) begin
      errors++;
      $display("FAIL afull_asserted: got afull never high, expected high while stalled");
    end
    checks++;
    if (!ok || err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL afull_delivery: got valid=%b err=%b pending=%0d, expected 1 0 0", ok, err, exp_q.size());
    end
    pulse_consume();
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_bad_ctrl();
`ifdef UNIT_PKT_RX_CHECK_EN
    bit seen;
    build_pkt(8, 1'b0, 3);
    drive_bytes(200);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || dbg_state !== ST_ERR) begin
      errors++;
      $display("FAIL bad_ctrl_err: got err=%b state=%0d, expected err=1 state=ERR", err, dbg_state);
    end
    // Input is drained and discarded while in ERR.
    tx_q.push_back({1'b1, 8'h2B});
    drive_bytes(20);
    repeat (4) @(negedge CLK);
    checks++;
    if (ready !== 1'b0 || err !== 1'b1 || pkt_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_ctrl_hold: got ready=%b err=%b pv=%b pending=%0d, expected 0 1 0 0",
               ready, err, pkt_valid, exp_q.size());
    end
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL bad_ctrl_recover: got ready=%b err=%b, expected 1 0", ready, err);
    end
`else
    bit ok;
    build_pkt(8, 1'b0, 3);
    drive_bytes(200);
    wait_pkt_valid(100, ok);
    checks++;
    if (!ok || err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_ctrl_terminate: got valid=%b err=%b pending=%0d, expected 1 0 0", ok, err, exp_q.size());
    end
    pulse_consume();
    repeat (2) @(negedge CLK);
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    build_pkt(9, 1'b0, 0);
    while (tx_q.size() > 18) void'(tx_q.pop_back());
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    drive_bytes(100);
    repeat (5) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({afull, ready, mem_wr_en, pkt_valid, init_valid, init_data, err, mem_addr, mem_dout} !== '0
        || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_outputs: got afull=%b ready=%b wr=%b pv=%b iv=%b id=%0d err=%b addr=%0d dout=%h st=%0d, expected 0",
               afull, ready, mem_wr_en, pkt_valid, init_valid, init_data, err, mem_addr, mem_dout, dbg_state);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_partial_words: got %0d pending, expected 0", exp_q.size());
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    build_pkt(9, 1'b0, 0);
    drive_bytes(200);
    wait_pkt_valid(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_next_pkt: got valid=%b pending=%0d err=%b, expected 1 0 0", ok, exp_q.size(), err);
    end
    pulse_consume();
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_init();
    test_data_pkt();
    test_consume();
    test_afull();
    test_bad_ctrl();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || init_exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queues: got %0d writes and %0d inits pending, expected 0", exp_q.size(), init_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unit_pkt_rx.md
UNIT_PKT_RX -- requirements
Module: unit_pkt_rx

Interface
REQ-001 SHALL have parameter WORD_MAX_LEN, 64, maximum key length in bytes (multiple of 4).
REQ-002 SHALL have parameter FIFO_DEPTH, 16, input buffer depth in entries (power of 2).
REQ-003 SHALL have parameter AFULL_MARGIN, 4, number of free entries at or below which afull asserts.
REQ-004 SHALL have port CLK  in  1  single clock for all logic (core clock domain).
REQ-005 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in  in  8  broadcast byte from the arbiter.
REQ-007 SHALL have port in_ctrl  in  1  marks a header byte or the last key byte.
REQ-008 SHALL have port wr_en  in  1  this unit's write strobe.
REQ-009 SHALL have port afull  out  1  input buffer almost full.
REQ-010 SHALL have port ready  out  1  unit can accept a new data packet.
REQ-011 SHALL have port mem_wr_en, mem_addr, mem_dout  out  1, clog2(10+WORD_MAX_LEN/4), 32  word write port into unit memory.
REQ-012 SHALL have port pkt_valid  out  1  complete packet in memory; pkt_consumed  in  1  core has finished with it.
REQ-013 SHALL have port init_valid  out  1  one-cycle pulse on init packet; init_data  out  5  latched init payload.
REQ-014 SHALL have port err  out  1  sticky protocol error.

Function
REQ-015 SHALL write {in_ctrl,in} into the FIFO on every cycle wr_en=1; a write while full SHALL be dropped and set err.
REQ-016 SHALL assert afull when free entries <= AFULL_MARGIN; this absorbs the 2-cycle sender reaction delay.
REQ-017 SHALL parse in state IDLE: a ctrl=1 byte with bits[2:0]=001 is an init packet, one with value 0 is a data header, and anything else sets err.
REQ-018 SHALL handle an init packet by latching init_data=byte[7:3] and pulsing init_valid for 1 cycle; it SHALL stay in IDLE and tolerate the sender writing the same init byte twice back-to-back (two pulses, same data).
REQ-019 SHALL, after a data header, go to state BODY, assemble body bytes little-endian into 32-bit words, and write word k to mem_addr=k with mem_wr_en=1 for one cycle on the cycle after its 4th byte is popped.
REQ-020 SHALL use this word layout: 0 cnt, 1 salt_len, 2..5 salt, 6..7 IDs {gen_id,pkt_id,word_id}, 8 key_len (byte 0), 9 unused, 10.. key.
REQ-021 SHALL take key_len from the byte at body offset 32 (the first byte of word 8); expected key bytes = 4*ceil(key_len/4).
REQ-022 SHALL go to state KEY at word 10; the byte with ctrl=1 SHALL terminate the packet, then go to state FULL with pkt_valid=1.
REQ-023 SHALL set err if ctrl=1 arrives in BODY or before the expected key byte count, if the expected count is exceeded without ctrl, or if key_len=0 or key_len>WORD_MAX_LEN.
REQ-024 SHALL, in state FULL, stop popping, hold pkt_valid=1 until pkt_consumed=1, then return to IDLE the next cycle; pkt_consumed outside FULL is ignored.
REQ-025 SHALL drive ready=1 only in IDLE with the FIFO empty, registered with 1-cycle latency.
REQ-026 SHALL go to state ERR on err: it drains and discards FIFO input, keeps ready=0, and leaves only by reset.
REQ-027 SHALL pop at most one FIFO entry per cycle; on simultaneous push and pop the occupancy is unchanged.

Reset
REQ-028 SHALL, on RST_N low, asynchronously clear the FIFO pointers and enter IDLE, with afull=0, ready=0, mem_wr_en=0, pkt_valid=0, init_valid=0, init_data=0, err=0, mem_addr=0, mem_dout=0.
REQ-029 SHALL, when reset asserts mid-packet, discard the partial packet; memory contents are then undefined.

Configuration
REQ-030 SHALL, with UNIT_PKT_RX_CHECK_EN defined, implement every err condition of REQ-015, REQ-017, REQ-023 and REQ-026.
REQ-031 SHALL, without UNIT_PKT_RX_CHECK_EN, tie err to 0, remove state ERR, and terminate the packet on ctrl=1 alone.

Structure
REQ-032 SHALL place the state encoding, word-offset constants (CNT=0, SALT=2, IDS=6, KEYLEN=8, KEY=10) and header codes (DATA=0, INIT=3'b001) in shared package unit_pkt_pkg.
REQ-033 SHALL use one sub-module, unit_pkt_fifo (9-bit synchronous FIFO with free-count output).

Verification
REQ-034 SHALL verify: init byte 0x2B written twice -> two init_valid pulses, init_data=5, ready stays 1.
REQ-035 SHALL verify: data packet with key_len=5 ("abcde"+3 pad) -> 12 writes at addr 0..11, word 8=0x00000005, word 11 byte 0='e', then pkt_valid=1.
REQ-036 SHALL verify: afull honored by a sender stalling 2 cycles late, FIFO_DEPTH=16 -> no overflow, err=0, all 44 bytes delivered.
REQ-037 SHALL verify: pkt_consumed pulse while in FULL -> pkt_valid=0 next cycle, ready=1 one cycle later; a second packet is then accepted.
REQ-038 SHALL verify: ctrl=1 on the 3rd key byte of key_len=8 -> err=1, ready=0 until RST_N (with macro); without macro -> pkt_valid=1.
REQ-039 SHALL verify: RST_N low after 17 body bytes -> all outputs at reset values; the next complete packet parses correctly.
